// File: rtl/hue_fader.sv
// Hue-wheel colour fader: steps a position around a six-segment hue wheel at a programmable rate
// and drives three glitch-free PWM channels from the decoded duties.
module hue_fader #(
  parameter int unsigned PWM_INTERVAL  = 1200,
  parameter int unsigned STEPS         = 100,
  parameter int unsigned TICK_INTERVAL = 20000,
  parameter int unsigned DW            = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          reverse,
  input  logic [1:0]    speed,
  output logic [DW-1:0] red_duty,
  output logic [DW-1:0] green_duty,
  output logic [DW-1:0] blue_duty,
  output logic          red_pwm,
  output logic          green_pwm,
  output logic          blue_pwm,
  output logic [2:0]    segment,
  output logic          wrap
);

  localparam int unsigned STEP_VAL = PWM_INTERVAL / STEPS;
  localparam int unsigned KW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned TW = $clog2(TICK_INTERVAL);
  localparam int unsigned PW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam logic [KW-1:0] KMax = KW'(STEPS - 1);
  localparam logic [DW-1:0] Full = DW'(PWM_INTERVAL);
  localparam logic [PW-1:0] PcMax = PW'(PWM_INTERVAL - 1);

  if (PWM_INTERVAL % STEPS != 0) begin : g_bad_steps
    $error("hue_fader: PWM_INTERVAL must be a multiple of STEPS");
  end
  if (TICK_INTERVAL < 8) begin : g_bad_tick
    $error("hue_fader: TICK_INTERVAL must be at least 8");
  end

  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    seg_q, seg_d;
  logic [KW-1:0] k_q, k_d;
  logic          wrap_q, wrap_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [2:0][DW-1:0] duty, sh_q, sh_d;
  logic [2:0]    pin_q, pin_d;
  logic [31:0]   period;
  logic          tick;
  logic [DW-1:0] up, dn;

  assign period = 32'(TICK_INTERVAL) >> speed;
  // Compare with >= so a speed increase mid-count ticks at once instead of overrunning.
  assign tick   = 32'(cnt_q) >= (period - 32'd1);
  assign cnt_d  = tick ? '0 : cnt_q + TW'(1);

  always_comb begin
    seg_d  = seg_q;
    k_d    = k_q;
    wrap_d = 1'b0;
    if (tick && enable) begin
      if (!reverse) begin
        if (k_q == KMax) begin
          k_d = '0;
          if (seg_q == 3'd5) begin
            seg_d  = 3'd0;
            wrap_d = 1'b1;
          end else begin
            seg_d = seg_q + 3'd1;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end else begin
        if (k_q == '0) begin
          k_d = KMax;
          if (seg_q == 3'd0) begin
            seg_d  = 3'd5;
            wrap_d = 1'b1;
          end else begin
            seg_d = seg_q - 3'd1;
          end
        end else begin
          k_d = k_q - KW'(1);
        end
      end
    end
  end

  assign up = DW'(32'(k_q) * STEP_VAL);
  assign dn = Full - up;

  // duty[2]=red, duty[1]=green, duty[0]=blue
  always_comb begin
    duty = '0;
    case (seg_q)
      3'd0:    duty = {Full, up, DW'(0)};
      3'd1:    duty = {dn, Full, DW'(0)};
      3'd2:    duty = {DW'(0), Full, up};
      3'd3:    duty = {DW'(0), dn, Full};
      3'd4:    duty = {up, DW'(0), Full};
      3'd5:    duty = {Full, DW'(0), dn};
      default: duty = {Full, DW'(0), DW'(0)};
    endcase
  end

  assign pc_d = (pc_q == PcMax) ? '0 : pc_q + PW'(1);

  // The pin compares against the value being latched so a new period starts with its own duty.
  always_comb begin
    sh_d  = sh_q;
    pin_d = '0;
    for (int c = 0; c < 3; c++) begin
      if (pc_q == '0) sh_d[c] = duty[c];
      pin_d[c] = DW'(pc_q) < sh_d[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      seg_q  <= 3'd0;
      k_q    <= '0;
      wrap_q <= 1'b0;
      pc_q   <= '0;
      sh_q   <= {Full, DW'(0), DW'(0)};
      pin_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      seg_q  <= seg_d;
      k_q    <= k_d;
      wrap_q <= wrap_d;
      pc_q   <= pc_d;
      sh_q   <= sh_d;
      pin_q  <= pin_d;
    end
  end

  assign red_duty   = duty[2];
  assign green_duty = duty[1];
  assign blue_duty  = duty[0];
  assign red_pwm    = pin_q[2];
  assign green_pwm  = pin_q[1];
  assign blue_pwm   = pin_q[0];
  assign segment    = seg_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_hue_fader.sv
// Bench for hue_fader with small parameters: vector table through a scoreboard queue plus
// hand-written PWM, hold and mid-run reset sequences.
module tb_hue_fader;

  localparam int unsigned PI = 12;
  localparam int unsigned ST = 4;
  localparam int unsigned TI = 8;
  localparam int unsigned DW = $clog2(PI + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          reverse = 1'b0;
  logic [1:0]    speed = 2'd0;
  logic [DW-1:0] red_duty, green_duty, blue_duty;
  logic          red_pwm, green_pwm, blue_pwm;
  logic [2:0]    segment;
  logic          wrap;

  hue_fader #(
    .PWM_INTERVAL (PI),
    .STEPS        (ST),
    .TICK_INTERVAL(TI)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .reverse   (reverse),
    .speed     (speed),
    .red_duty  (red_duty),
    .green_duty(green_duty),
    .blue_duty (blue_duty),
    .red_pwm   (red_pwm),
    .green_pwm (green_pwm),
    .blue_pwm  (blue_pwm),
    .segment   (segment),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit en; bit rev; int spd; int ncyc;
    int seg; int r; int g; int b; int w;
  } vec_t;

  typedef struct {int seg; int r; int g; int b; int w;} exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [11:0] win_sb[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge (or time 0); leaves rst_n released at a negedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rst_seg"}, int'(segment), 0);
    chk({tag, "_rst_red"}, int'(red_duty), PI);
    chk({tag, "_rst_green"}, int'(green_duty), 0);
    chk({tag, "_rst_blue"}, int'(blue_duty), 0);
    chk({tag, "_rst_pins"}, int'({red_pwm, green_pwm, blue_pwm}), 0);
    chk({tag, "_rst_wrap"}, int'(wrap), 0);
    rst_n = 1'b1;
  endtask

  function automatic void add(bit rst, bit en, bit rev, int spd, int n,
                              int seg, int r, int g, int b, int w);
    vec_t v;
    v = '{rst: rst, en: en, rev: rev, spd: spd, ncyc: n, seg: seg, r: r, g: g, b: b, w: w};
    vecs.push_back(v);
  endfunction

  initial begin
    exp_t        e;
    logic [11:0] gwin, rwin, bwin, expw;
    int          bh, brise, gh, rh, waited;
    logic        prev;

    // Forward from reset: cumulative cycle counts 8,16,32,56,64,104,136,184,191,192,193.
    add(1, 1, 0, 0, 8,  0, 12, 3, 0, 0);
    add(0, 1, 0, 0, 8,  0, 12, 6, 0, 0);
    add(0, 1, 0, 0, 16, 1, 12, 12, 0, 0);
    add(0, 1, 0, 0, 24, 1, 3, 12, 0, 0);
    add(0, 1, 0, 0, 8,  2, 0, 12, 0, 0);
    add(0, 1, 0, 0, 40, 3, 0, 9, 12, 0);
    add(0, 1, 0, 0, 32, 4, 3, 0, 12, 0);
    add(0, 1, 0, 0, 48, 5, 12, 0, 3, 0);
    add(0, 1, 0, 0, 7,  5, 12, 0, 3, 0);
    add(0, 1, 0, 0, 1,  0, 12, 0, 0, 1);
    add(0, 1, 0, 0, 1,  0, 12, 0, 0, 0);
    // Reverse from reset wraps to (5, 3) on the first tick.
    add(1, 1, 1, 0, 8,  5, 12, 0, 3, 1);
    add(0, 1, 1, 0, 1,  5, 12, 0, 3, 0);
    add(0, 1, 1, 0, 7,  5, 12, 0, 6, 0);
    // speed=2 steps every 2 cycles; drop to speed=0 at prescaler count 1.
    add(1, 1, 0, 2, 2,  0, 12, 3, 0, 0);
    add(0, 1, 0, 2, 2,  0, 12, 6, 0, 0);
    add(0, 1, 0, 2, 1,  0, 12, 6, 0, 0);
    add(0, 1, 0, 0, 6,  0, 12, 6, 0, 0);
    add(0, 1, 0, 0, 1,  0, 12, 9, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset($sformatf("vec%0d", i));
      enable  = vecs[i].en;
      reverse = vecs[i].rev;
      speed   = 2'(vecs[i].spd);
      sb.push_back('{seg: vecs[i].seg, r: vecs[i].r, g: vecs[i].g, b: vecs[i].b, w: vecs[i].w});
      cycles(vecs[i].ncyc);
      e = sb.pop_front();
      chk($sformatf("vec%0d_seg", i), int'(segment), e.seg);
      chk($sformatf("vec%0d_red", i), int'(red_duty), e.r);
      chk($sformatf("vec%0d_green", i), int'(green_duty), e.g);
      chk($sformatf("vec%0d_blue", i), int'(blue_duty), e.b);
      chk($sformatf("vec%0d_wrap", i), int'(wrap), e.w);
    end

    // PWM windows: green duty changes mid-period but pins follow the latched value.
    enable = 1'b0; reverse = 1'b0; speed = 2'd0;
    do_reset("pwm");
    enable = 1'b1;
    win_sb.push_back(12'h000);
    win_sb.push_back(12'h007);
    win_sb.push_back(12'h1FF);
    win_sb.push_back(12'hFFF);
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 12; i++) begin
        cycles(1);
        if (w == 0 && i == 0) chk("pwm_first_red", int'(red_pwm), 1);
        gwin[i] = green_pwm;
        rwin[i] = red_pwm;
        bwin[i] = blue_pwm;
      end
      expw = win_sb.pop_front();
      chk($sformatf("pwm_green_win%0d", w), int'(gwin), int'(expw));
      chk($sformatf("pwm_red_win%0d", w), int'(rwin), 'hFFF);
      chk($sformatf("pwm_blue_win%0d", w), int'(bwin), 0);
    end

    // Hold mid-segment-2: duties freeze, pins keep running.
    enable = 1'b0;
    do_reset("hold");
    enable = 1'b1;
    cycles(72);
    chk("hold_pre_seg", int'(segment), 2);
    chk("hold_pre_blue", int'(blue_duty), 3);
    enable = 1'b0;
    cycles(88);
    chk("hold_seg", int'(segment), 2);
    chk("hold_green", int'(green_duty), 12);
    bh = 0; brise = 0; gh = 0; rh = 0;
    prev = blue_pwm;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      bh += int'(blue_pwm);
      gh += int'(green_pwm);
      rh += int'(red_pwm);
      if (blue_pwm && !prev) brise++;
      prev = blue_pwm;
    end
    chk("hold_blue_high", bh, 3);
    chk("hold_blue_rises", brise, 1);
    chk("hold_green_high", gh, 12);
    chk("hold_red_high", rh, 0);
    chk("hold_blue_frozen", int'(blue_duty), 3);
    enable = 1'b1;
    waited = 0;
    for (int i = 1; i <= 8; i++) begin
      cycles(1);
      if (blue_duty != 3) begin
        waited = i;
        break;
      end
    end
    chk("reenable_step_within_8", int'(waited >= 1 && waited <= 8), 1);
    chk("reenable_blue", int'(blue_duty), 6);

    // Reset mid-segment-3 aborts the run and the sequence restarts.
    enable = 1'b0;
    do_reset("mid");
    enable = 1'b1;
    cycles(108);
    chk("mid_pre_seg", int'(segment), 3);
    chk("mid_pre_green", int'(green_duty), 9);
    do_reset("mid2");
    cycles(8);
    chk("mid_post_seg", int'(segment), 0);
    chk("mid_post_green", int'(green_duty), 3);
    chk("mid_post_red", int'(red_duty), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hue_fader.md
# hue_fader

Parametrised hue-wheel colour fader driving an RGB LED. It steps a position around a six-segment hue wheel (red → yellow → green → cyan → blue → magenta → red) at a programmable rate, in either direction, with pause. It derives the three duty values from that position and generates glitch-free PWM waveforms for each channel. It replaces the fixed-rate, forward-only fade sequencer plus external PWM stage in the LED path.

## Interface
- `PWM_INTERVAL`, 1200: PWM period in clk cycles; also the full-scale duty value.
- `STEPS`, 100: steps per hue segment. `PWM_INTERVAL % STEPS` must be 0; elaboration fails otherwise.
- `TICK_INTERVAL`, 20000: base clk cycles per step at `speed`=0. Must be ≥ 8.
- `DW`, $clog2(PWM_INTERVAL+1): duty width (derived, do not override).
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `enable` in 1: 1 = advance the hue position on ticks; 0 = hold the position. The PWM outputs keep running while held.
- `reverse` in 1: 0 = step forward around the wheel, 1 = step backward.
- `speed` in 2: the tick period is `TICK_INTERVAL >> speed`.
- `red_duty`, `green_duty`, `blue_duty` out DW: current duty values (0..PWM_INTERVAL).
- `red_pwm`, `green_pwm`, `blue_pwm` out 1: registered PWM pins.
- `segment` out 3: current hue segment, 0..5.
- `wrap` out 1: one-cycle pulse when the position wraps around the wheel.

## Operation
- `STEP_VAL` = PWM_INTERVAL/STEPS. Hue position is held as `segment` (0..5) plus step `k` (0..STEPS-1).
- Define `up` = k·STEP_VAL and `dn` = PWM_INTERVAL − up. Duty decode (R,G,B) per segment:
  - seg0 = (full, up, 0)
  - seg1 = (dn, full, 0)
  - seg2 = (0, full, up)
  - seg3 = (0, dn, full)
  - seg4 = (up, 0, full)
  - seg5 = (full, 0, dn)
- The decode is continuous across segment boundaries. Duties are a pure function of the segment/k registers.
- Prescaler: counts 0..T−1, where T = TICK_INTERVAL>>speed.
  - When the count is ≥ T−1, the cycle is a tick and the counter goes to 0.
  - A speed change mid-count therefore ticks on the next cycle if the count already exceeds the new T−1.
  - The prescaler always runs, independent of `enable`.
- On a tick with `enable`=1:
  - Forward: k+1. At k=STEPS−1, k→0 and segment+1. At segment 5, segment→0.
  - Reverse: k−1. At k=0, k→STEPS−1 and segment−1. At segment 0, segment→5.
  - A tick with `enable`=0 is discarded; no position change.
- `wrap` asserts on the cycle after the position changes across the wheel wrap:
  - forward from (5, STEPS−1) to (0, 0);
  - reverse from (0, 0) to (5, STEPS−1).
- PWM:
  - A free-running counter `pc` counts 0..PWM_INTERVAL−1.
  - At pc=0 each channel latches its current duty into a shadow register.
  - The pin register takes (pc < shadow).
  - Duty changes mid-period never affect the current period.
  - Duty 0 → pin constant 0; duty PWM_INTERVAL → pin constant 1.
- A `reverse` change takes effect on the next tick. No skipped or repeated step beyond the direction change itself.

## Timing
- Reset (rst_n=0 at a rising edge), after that edge:
  - segment=0, k=0, prescaler=0, pc=0, wrap=0;
  - red_duty=PWM_INTERVAL, green_duty=0, blue_duty=0;
  - shadow registers R=PWM_INTERVAL, G=0, B=0; all pwm pins 0.
- Reset mid-operation aborts everything with the same values; no partial step survives.
- First pin update is at the edge after reset release: red_pwm=1 from that cycle, because shadow R=full.
- Step latency: segment/k and the duty outputs change at the clk edge ending the tick cycle.
- Pin latency: a pin reflects (pc < shadow) one cycle after the pc value.
- New duty reaches the pins at the next pc=0 latch, i.e. within PWM_INTERVAL+1 cycles.
- Forward, enable=1, speed=0: full wheel = 6·STEPS·TICK_INTERVAL cycles; `wrap` once per revolution.

## Test plan
Bench parameters for all scenarios: PWM_INTERVAL=12, STEPS=4, TICK_INTERVAL=8, so STEP_VAL=3.

- Reset, then hold rst_n=1, enable=1, reverse=0, speed=0 → duties (12,0,0). After 8 cycles (12,3,0); after 32 cycles segment=1 and (12,12,0). After 192 cycles back to segment 0, k 0, with `wrap` high exactly 1 cycle.
- From reset, reverse=1 → first tick gives segment=5, k=3, duties (12,0,3) and `wrap` pulse. Next tick gives (12,0,6).
- enable=0 for 100 cycles mid-segment-2 → duties frozen; pins keep toggling with period 12. Re-enable: next step occurs within 8 cycles.
- speed=2 (T=2) → a step every 2 cycles. Switch to speed=0 at prescaler count 1 → next tick 7 cycles later.
- Duty change at pc=5 → pin pattern unchanged until the next pc=0. Duty 12 → green_pwm high 12/12 cycles; duty 3 → high exactly 3 consecutive cycles per period.
- Assert rst_n=0 for one cycle mid-segment-3 → all outputs return to reset values on that edge; sequence restarts from (12,0,0).
